// File: rtl/echo_pkg.sv
// -----------------------------------------------------------------------------
// echo_pkg
// Shared constants and types for the echo delay-line controller.
//   SAMPLE_W    : audio sample width (16-bit signed PCM)
//   BASE_DELAY  : default delay step in samples
//   NUM_DELAYS  : default number of selectable delays
//   SEL_W/ATT_W : widths of the delay-select and attenuation fields
//   state_e     : controller states (CLEAR only exists when
//                 ECHO_CTRL_CLEAR_EN is defined)
//   delay_of()  : delay length in samples for a given selection index
// -----------------------------------------------------------------------------
package echo_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int BASE_DELAY = 4800;
    localparam int NUM_DELAYS = 5;
    localparam int SEL_W      = 3;
    localparam int ATT_W      = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Delay for selection index sel is (sel+1) steps of base samples.
    function automatic int unsigned delay_of(input logic [SEL_W-1:0] sel,
                                             input int unsigned       base);
        return (32'(sel) + 32'd1) * base;
    endfunction

endpackage

// File: rtl/delay_addr_gen.sv
// -----------------------------------------------------------------------------
// delay_addr_gen
// Combinational read-address generator for the circular delay RAM.
// Returns (wr_ptr - delay) wrapped into the range 0..DEPTH-1.
//   i_wr_ptr : current write pointer (0..DEPTH-1)
//   i_delay  : delay in samples (< DEPTH)
//   o_raddr  : read address that is i_delay samples behind i_wr_ptr
// -----------------------------------------------------------------------------
module delay_addr_gen
    import echo_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 32768
) (
    input  logic [ADDR_W-1:0] i_wr_ptr,
    input  logic [ADDR_W-1:0] i_delay,
    output logic [ADDR_W-1:0] o_raddr
);

    // DEPTH may equal 2^ADDR_W, in which case this constant is 0. The wrapped
    // branch is still exact: the true result is below DEPTH, so computing it
    // modulo 2^ADDR_W loses nothing.
    localparam logic [ADDR_W-1:0] DEPTH_MOD = ADDR_W'(DEPTH);

    always_comb begin
        if (i_wr_ptr >= i_delay) begin
            o_raddr = i_wr_ptr - i_delay;
        end else begin
            o_raddr = i_wr_ptr + DEPTH_MOD - i_delay;
        end
    end

endmodule

// File: rtl/echo_ctrl.sv
// -----------------------------------------------------------------------------
// echo_ctrl
// Address/control generator for a single-tap echo effect built around an
// external simple dual-port delay RAM (1-cycle read latency).
//
// Build option: define ECHO_CTRL_CLEAR_EN to compile in the CLEAR state, which
// zero-fills the RAM after reset and after every delay change. Without it the
// echo term is instead muted until the delay line holds a full delay of fresh
// samples.
//
// Ports
//   clk        : sole clock
//   reset      : synchronous, active-high reset
//   sample_in  : signed dry sample, valid when in_ready=1
//   in_ready   : one-cycle sample strobe (>= 2 cycles apart)
//   next_D     : one-cycle pulse, advance delay selection
//   next_H     : one-cycle pulse, advance attenuation
//   ram_we     : RAM write enable
//   ram_waddr  : RAM write address
//   ram_wdata  : RAM write data
//   ram_raddr  : RAM read address (read data valid with out_ready)
//   out_ready  : in_ready delayed by one cycle
//   echo_valid : echo term qualifier, aligned with out_ready
//   delay_sel  : current delay index, 0..NUM_DELAYS-1
//   att_shift  : right-shift distance applied to the echo term
//   busy       : high while a RAM clear is in progress
// -----------------------------------------------------------------------------
module echo_ctrl
    import echo_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int DEPTH      = 32768,
    parameter int BASE_DELAY = echo_pkg::BASE_DELAY,
    parameter int NUM_DELAYS = echo_pkg::NUM_DELAYS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       in_ready,
    input  logic                       next_D,
    input  logic                       next_H,
    output logic                       ram_we,
    output logic [ADDR_W-1:0]          ram_waddr,
    output logic [SAMPLE_W-1:0]        ram_wdata,
    output logic [ADDR_W-1:0]          ram_raddr,
    output logic                       out_ready,
    output logic                       echo_valid,
    output logic [SEL_W-1:0]           delay_sel,
    output logic [ATT_W-1:0]           att_shift,
    output logic                       busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [SEL_W-1:0]  LAST_SEL  = SEL_W'(NUM_DELAYS - 1);

    // Registers common to both builds
    logic [SEL_W-1:0]  r_delay_sel;
    logic [ATT_W-1:0]  r_att_shift;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_raddr;
    logic              r_out_ready;
    logic              r_echo_valid;

    // Combinational helpers
    logic [SEL_W-1:0]  w_delay_sel_next;
    logic [ADDR_W-1:0] w_delay;
    logic [ADDR_W-1:0] w_raddr;
    logic [ADDR_W-1:0] w_wr_ptr_inc;
    logic [ADDR_W-1:0] w_wr_ptr_next;
    logic              w_accept;     // sample is written into the delay line

`ifdef ECHO_CTRL_CLEAR_EN
    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_next;
`else
    // Counts accepted samples still needed before the read pointer lands on
    // data written since the last reset / delay change.
    logic [ADDR_W-1:0] r_mute_cnt;
    logic [ADDR_W-1:0] w_delay_new;
`endif

    // ---------------------------------------------------------------------
    // Selection, delay and pointer arithmetic
    // ---------------------------------------------------------------------
    assign w_delay_sel_next = !next_D                    ? r_delay_sel :
                              (r_delay_sel == LAST_SEL)  ? '0          :
                                                           r_delay_sel + SEL_W'(1);

    assign w_delay      = ADDR_W'(delay_of(r_delay_sel, BASE_DELAY));
    assign w_wr_ptr_inc = (r_wr_ptr == LAST_ADDR) ? '0 : r_wr_ptr + ADDR_W'(1);

    delay_addr_gen #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_addr_gen (
        .i_wr_ptr (r_wr_ptr),
        .i_delay  (w_delay),
        .o_raddr  (w_raddr)
    );

    // The read address follows the write pointer only on accepted samples and
    // otherwise holds, so the RAM output stays stable between strobes.
    assign ram_raddr = w_accept ? w_raddr : r_raddr;

`ifdef ECHO_CTRL_CLEAR_EN
    // ---------------------------------------------------------------------
    // FSM next-state and RAM control
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves one unassigned, which would otherwise infer a latch.
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_wr_ptr_next  = r_wr_ptr;
        w_accept       = 1'b0;
        ram_we         = 1'b0;
        ram_waddr      = r_wr_ptr;
        ram_wdata      = '0;
        busy           = 1'b0;

        unique case (r_state)
            ST_CLEAR: begin
                // Zero-fill one location per cycle; incoming samples are
                // dropped and the write pointer stays parked at 0.
                ram_we    = 1'b1;
                ram_waddr = r_clr_cnt;
                busy      = 1'b1;
                if (next_D) begin
                    w_clr_cnt_next = '0;
                    w_wr_ptr_next  = '0;
                end else if (r_clr_cnt == LAST_ADDR) begin
                    w_state_next   = ST_RUN;
                    w_clr_cnt_next = '0;
                end else begin
                    w_clr_cnt_next = r_clr_cnt + ADDR_W'(1);
                end
            end

            ST_RUN: begin
                if (in_ready) begin
                    w_accept      = 1'b1;
                    ram_we        = 1'b1;
                    ram_wdata     = sample_in;
                    w_wr_ptr_next = w_wr_ptr_inc;
                end
                // A new delay invalidates the stored history: wipe the RAM.
                if (next_D) begin
                    w_state_next   = ST_CLEAR;
                    w_clr_cnt_next = '0;
                    w_wr_ptr_next  = '0;
                end
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end
`else
    // ---------------------------------------------------------------------
    // RAM control, always running
    // ---------------------------------------------------------------------
    always_comb begin
        w_accept      = in_ready;
        w_wr_ptr_next = in_ready ? w_wr_ptr_inc : r_wr_ptr;
        ram_we        = in_ready;
        ram_waddr     = r_wr_ptr;
        ram_wdata     = in_ready ? sample_in : '0;
        busy          = 1'b0;
    end

    // Mute length for the delay that takes effect after next_D.
    assign w_delay_new = ADDR_W'(delay_of(w_delay_sel_next, BASE_DELAY));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mute_cnt <= ADDR_W'(BASE_DELAY);
        end else if (next_D) begin
            r_mute_cnt <= w_delay_new;
        end else if (w_accept && (r_mute_cnt != '0)) begin
            r_mute_cnt <= r_mute_cnt - ADDR_W'(1);
        end
    end
`endif

    // ---------------------------------------------------------------------
    // Control registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples values from before this edge, independent of
        // statement order.
        if (reset) begin
            r_delay_sel  <= '0;
            r_att_shift  <= '0;
            r_wr_ptr     <= '0;
            r_raddr      <= '0;
            r_out_ready  <= 1'b0;
            r_echo_valid <= 1'b0;
        end else begin
            r_delay_sel  <= w_delay_sel_next;
            r_att_shift  <= r_att_shift + ATT_W'(next_H);
            r_wr_ptr     <= w_wr_ptr_next;
            r_out_ready  <= in_ready;
            if (w_accept) begin
                r_raddr <= w_raddr;
            end
`ifdef ECHO_CTRL_CLEAR_EN
            r_echo_valid <= w_accept;
`else
            r_echo_valid <= w_accept && (r_mute_cnt == '0);
`endif
        end
    end

    // NOTE: the delay RAM itself has no reset; its contents are made
    // harmless either by the CLEAR zero-fill or by muting the echo term.
    assign out_ready  = r_out_ready;
    assign echo_valid = r_echo_valid;
    assign delay_sel  = r_delay_sel;
    assign att_shift  = r_att_shift;

endmodule
